// File: rtl/stg_pkg.sv
// ----------------------------------------------------------------------------
// stg_pkg
// Shared constants and types for the STG playfield blocks.
//   MAX_X / MAX_Y        playfield size in pixels
//   LASER_W              laser sprite width in pixels
//   LASER_RST_X/Y        laser anchor value held in reset
//   laser_state_t        laser sequencer FSM state encoding
// ----------------------------------------------------------------------------
package stg_pkg;

   localparam int MAX_X   = 384;
   localparam int MAX_Y   = 448;
   localparam int LASER_W = 16;

   localparam logic [9:0] LASER_RST_X = 10'd192;
   localparam logic [9:0] LASER_RST_Y = 10'd399;

   typedef enum logic [1:0] {
      LASER_IDLE   = 2'd0,
      LASER_CHARGE = 2'd1,
      LASER_FIRE   = 2'd2,
      LASER_COOL   = 2'd3
   } laser_state_t;

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Game-tick prescaler. Counts 0..DIV-1 and wraps; tick is high for exactly
// the one cycle in which the count equals DIV-1.
//   clk    in   system clock
//   reset  in   asynchronous, active-high; count restarts from 0
//   tick   out  registered one-cycle tick pulse
// ----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 2000000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

   // tick is registered from the next count so it lines up with cnt == LAST
   // without a combinational path to the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (cnt_nxt == LAST);
      end
   end

endmodule

// File: rtl/laser_ctrl.sv
// ----------------------------------------------------------------------------
// laser_ctrl
// Player laser sequencer. Gates fire requests against an energy gauge and
// runs IDLE -> CHARGE -> FIRE -> COOL on the game tick. The laser anchor is
// snapshotted from the player position while charging/firing and clamped to
// the playfield.
//   clk, reset           system clock, asynchronous active-high reset
//   fire_btn             level fire request (sampled on ticks)
//   bomb_active          inhibits / aborts the laser (sampled on ticks)
//   player_x, player_y   player sprite position
//   laser_x, laser_y     registered laser anchor
//   shooting / charging  registered state decodes (FIRE / CHARGE)
//   overheat             cooldown caused by energy exhaustion
//   energy               gauge, 0..ENERGY_MAX
//   tick                 game-tick pulse, shared with other blocks
// ----------------------------------------------------------------------------
module laser_ctrl
   import stg_pkg::*;
#(
   parameter int TICK_DIV        = 2000000,
   parameter int CHARGE_TICKS    = 3,
   parameter int ENERGY_MAX      = 100,
   parameter int MIN_FIRE_ENERGY = 20,
   parameter int DRAIN           = 2,
   parameter int REGEN           = 1,
   parameter int COOL_TICKS      = 25,
   parameter int X_OFFSET        = 7,
   parameter int Y_OFFSET        = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fire_btn,
   input  logic       bomb_active,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   output logic [9:0] laser_x,
   output logic [9:0] laser_y,
   output logic       shooting,
   output logic       charging,
   output logic       overheat,
   output logic [6:0] energy,
   output logic       tick
);

   localparam int CCW = $clog2(CHARGE_TICKS + 1);
   localparam int KW  = $clog2(2 * COOL_TICKS + 1);

   localparam logic [6:0]     EN_MAX   = 7'(ENERGY_MAX);
   localparam logic [6:0]     EN_MIN   = 7'(MIN_FIRE_ENERGY);
   localparam logic [6:0]     EN_DRAIN = 7'(DRAIN);
   localparam logic [7:0]     EN_REGEN = 8'(REGEN);
   localparam logic [CCW-1:0] CHG_END  = CCW'(CHARGE_TICKS);
   localparam logic [KW-1:0]  COOL_N   = KW'(COOL_TICKS);
   localparam logic [KW-1:0]  COOL_OVH = KW'(2 * COOL_TICKS);

   localparam logic signed [10:0] X_OFF = 11'(X_OFFSET);
   localparam logic signed [10:0] Y_OFF = 11'(Y_OFFSET);
   localparam logic signed [10:0] X_HI  = 11'(MAX_X - LASER_W);
   localparam logic signed [10:0] Y_LO  = 11'sd1;
   localparam logic signed [10:0] Y_HI  = 11'(MAX_Y - 1);

   // ---------------------------------------------------------------- prescaler
   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // ---------------------------------------------------------------- state
   laser_state_t   state;
   laser_state_t   state_nxt;
   logic [CCW-1:0] chg_cnt;
   logic [CCW-1:0] chg_nxt;
   logic [CCW-1:0] chg_inc;
   logic [KW-1:0]  cool_cnt;
   logic [KW-1:0]  cool_nxt;
   logic [KW-1:0]  cool_dec;
   logic [6:0]     energy_nxt;
   logic           ovh_nxt;

   // ---------------------------------------------------------------- energy
   logic [7:0] en_sum;
   logic [6:0] en_regen;
   logic [6:0] en_drain;

   assign en_sum   = {1'b0, energy} + EN_REGEN;
   assign en_regen = (en_sum > {1'b0, EN_MAX}) ? EN_MAX : en_sum[6:0];
   assign en_drain = (energy > EN_DRAIN) ? (energy - EN_DRAIN) : 7'd0;

   assign chg_inc  = chg_cnt + 1'b1;
   assign cool_dec = cool_cnt - 1'b1;

   always_comb begin
      state_nxt  = state;
      energy_nxt = energy;
      chg_nxt    = chg_cnt;
      cool_nxt   = cool_cnt;
      ovh_nxt    = overheat;
      case (state)
         LASER_IDLE: begin
            // Entry check uses the gauge before this tick's regen.
            energy_nxt = en_regen;
            if (fire_btn && !bomb_active && (energy >= EN_MIN)) begin
               state_nxt = LASER_CHARGE;
               chg_nxt   = '0;
            end
         end
         LASER_CHARGE: begin
            if (!fire_btn || bomb_active) begin
               state_nxt = LASER_IDLE;
            end else begin
               chg_nxt = chg_inc;
               if (chg_inc == CHG_END) begin
                  state_nxt = LASER_FIRE;
               end
            end
         end
         LASER_FIRE: begin
            energy_nxt = en_drain;
            // Exhaustion wins over a release/bomb on the same tick.
            if (en_drain == 7'd0) begin
               state_nxt = LASER_COOL;
               ovh_nxt   = 1'b1;
               cool_nxt  = COOL_OVH;
            end else if (!fire_btn || bomb_active) begin
               state_nxt = LASER_COOL;
               ovh_nxt   = 1'b0;
               cool_nxt  = COOL_N;
            end
         end
         LASER_COOL: begin
            cool_nxt = cool_dec;
            if (cool_dec == '0) begin
               state_nxt = LASER_IDLE;
               ovh_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = LASER_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- anchor clamp
   // Computed one bit wider and signed so a small player_x clamps to 0
   // instead of wrapping to a large value.
   logic signed [10:0] x_diff;
   logic signed [10:0] y_diff;
   logic [9:0]         x_clamp;
   logic [9:0]         y_clamp;

   assign x_diff = $signed({1'b0, player_x}) - X_OFF;
   assign y_diff = $signed({1'b0, player_y}) - Y_OFF;

   always_comb begin
      if (x_diff < 11'sd0) begin
         x_clamp = 10'd0;
      end else if (x_diff > X_HI) begin
         x_clamp = X_HI[9:0];
      end else begin
         x_clamp = x_diff[9:0];
      end

      if (y_diff < Y_LO) begin
         y_clamp = Y_LO[9:0];
      end else if (y_diff > Y_HI) begin
         y_clamp = Y_HI[9:0];
      end else begin
         y_clamp = y_diff[9:0];
      end
   end

   // ---------------------------------------------------------------- registers
   // Everything advances only on tick cycles and holds in between.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= LASER_IDLE;
         energy   <= EN_MAX;
         chg_cnt  <= '0;
         cool_cnt <= '0;
         overheat <= 1'b0;
         shooting <= 1'b0;
         charging <= 1'b0;
         laser_x  <= LASER_RST_X;
         laser_y  <= LASER_RST_Y;
      end else if (tick) begin
         state    <= state_nxt;
         energy   <= energy_nxt;
         chg_cnt  <= chg_nxt;
         cool_cnt <= cool_nxt;
         overheat <= ovh_nxt;
         shooting <= (state_nxt == LASER_FIRE);
         charging <= (state_nxt == LASER_CHARGE);
         if ((state == LASER_CHARGE) || (state == LASER_FIRE)) begin
            laser_x <= x_clamp;
            laser_y <= y_clamp;
         end
      end
   end

endmodule

// File: tb/tb_laser_ctrl.sv
// ----------------------------------------------------------------------------
// tb_laser_ctrl
// Self-checking bench for laser_ctrl. A behavioural model advances on each
// modelled tick and pushes the expected outputs; they are popped and
// compared one cycle later, when the DUT shows its registered result.
// ----------------------------------------------------------------------------
module tb_laser_ctrl;

   localparam int TICK_DIV     = 4;
   localparam int CHARGE_TICKS = 3;
   localparam int ENERGY_MAX   = 100;
   localparam int MIN_FIRE     = 20;
   localparam int DRAIN        = 2;
   localparam int REGEN        = 1;
   localparam int COOL_TICKS   = 5;

   // ---------------------------------------------------------------- clock / reset
   logic       clk = 1'b0;
   logic       reset;
   logic       fire_btn;
   logic       bomb_active;
   logic [9:0] player_x;
   logic [9:0] player_y;
   logic [9:0] laser_x;
   logic [9:0] laser_y;
   logic       shooting;
   logic       charging;
   logic       overheat;
   logic [6:0] energy;
   logic       tick;

   always #5 clk = ~clk;

   laser_ctrl #(
      .TICK_DIV        (TICK_DIV),
      .CHARGE_TICKS    (CHARGE_TICKS),
      .ENERGY_MAX      (ENERGY_MAX),
      .MIN_FIRE_ENERGY (MIN_FIRE),
      .DRAIN           (DRAIN),
      .REGEN           (REGEN),
      .COOL_TICKS      (COOL_TICKS),
      .X_OFFSET        (7),
      .Y_OFFSET        (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fire_btn    (fire_btn),
      .bomb_active (bomb_active),
      .player_x    (player_x),
      .player_y    (player_y),
      .laser_x     (laser_x),
      .laser_y     (laser_y),
      .shooting    (shooting),
      .charging    (charging),
      .overheat    (overheat),
      .energy      (energy),
      .tick        (tick)
   );

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   logic [29:0] exp_q[$];
   int ticks_seen = 0;
   int n_shoot    = 0;
   int n_ovh      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   int m_cnt, m_st, m_en, m_cc, m_cool, m_lx, m_ly;
   bit m_tick, m_ovh;

   task automatic model_reset();
      m_cnt  = 0;
      m_tick = 1'b0;
      m_st   = 0;
      m_en   = ENERGY_MAX;
      m_cc   = 0;
      m_cool = 0;
      m_lx   = 192;
      m_ly   = 399;
      m_ovh  = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [29:0] model_outs();
      return {10'(m_lx), 10'(m_ly), (m_st == 2), (m_st == 1), m_ovh, 7'(m_en)};
   endfunction

   // states: 0 idle, 1 charge, 2 fire, 3 cool
   task automatic model_tick();
      int ex, ey;
      ex = int'(player_x) - 7;
      if (ex < 0)   ex = 0;
      if (ex > 368) ex = 368;
      ey = int'(player_y) - 1;
      if (ey < 1)   ey = 1;
      if (ey > 447) ey = 447;
      case (m_st)
         0: begin
            if (fire_btn && !bomb_active && m_en >= MIN_FIRE) begin
               m_st = 1;
               m_cc = 0;
            end
            m_en = (m_en + REGEN > ENERGY_MAX) ? ENERGY_MAX : m_en + REGEN;
         end
         1: begin
            m_lx = ex;
            m_ly = ey;
            if (!fire_btn || bomb_active) m_st = 0;
            else begin
               m_cc++;
               if (m_cc == CHARGE_TICKS) m_st = 2;
            end
         end
         2: begin
            m_lx = ex;
            m_ly = ey;
            m_en = (m_en > DRAIN) ? m_en - DRAIN : 0;
            if (m_en == 0) begin
               m_st = 3; m_ovh = 1'b1; m_cool = 2 * COOL_TICKS;
            end else if (!fire_btn || bomb_active) begin
               m_st = 3; m_ovh = 1'b0; m_cool = COOL_TICKS;
            end
         end
         default: begin
            m_cool--;
            if (m_cool == 0) begin
               m_st = 0; m_ovh = 1'b0;
            end
         end
      endcase
   endtask

   // ---------------------------------------------------------------- driver tasks
   // One clock: advance the model on modelled tick edges, then sample #1 later.
   task automatic cycle();
      logic [29:0] e;
      @(posedge clk);
      if (m_tick) begin
         model_tick();
         exp_q.push_back(model_outs());
      end
      m_cnt  = (m_cnt == TICK_DIV - 1) ? 0 : m_cnt + 1;
      m_tick = (m_cnt == TICK_DIV - 1);
      #1;
      check("tick", tick, m_tick);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("laser_x",  laser_x,  e[29:20]);
         check("laser_y",  laser_y,  e[19:10]);
         check("shooting", shooting, e[9]);
         check("charging", charging, e[8]);
         check("overheat", overheat, e[7]);
         check("energy",   energy,   e[6:0]);
         ticks_seen++;
         if (shooting) n_shoot++;
         if (overheat) n_ovh++;
      end
   endtask

   task automatic run_ticks(input int n);
      int t0;
      t0 = ticks_seen;
      while (ticks_seen - t0 < n) cycle();
   endtask

   // Counts clock edges from reset release until tick is seen high: the
   // tick should occupy the 4th clock period, i.e. after the 3rd edge.
   task automatic first_tick(input string tag);
      int n;
      n = 0;
      while (tick !== 1'b1 && n < 8) begin
         cycle();
         n++;
      end
      check(tag, n, 3);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_energy"},   energy,   100);
      check({tag, "_laser_x"},  laser_x,  192);
      check({tag, "_laser_y"},  laser_y,  399);
      check({tag, "_shooting"}, shooting, 0);
      check({tag, "_charging"}, charging, 0);
      check({tag, "_overheat"}, overheat, 0);
      check({tag, "_tick"},     tick,     0);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      int guard;
      reset       = 1'b1;
      fire_btn    = 1'b0;
      bomb_active = 1'b0;
      player_x    = 10'd200;
      player_y    = 10'd300;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("por");
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // Overheat: button held from full energy.
      fire_btn = 1'b1;
      first_tick("por_first_tick");
      n_shoot = 0;
      n_ovh   = 0;
      run_ticks(64);
      check("ovh_fire_ticks", n_shoot, 50);
      check("ovh_cool_ticks", n_ovh, 10);
      check("ovh_clear", overheat, 0);
      check("ovh_energy", energy, 0);

      // Low energy: stays idle until the gauge reads 20, then charges.
      n = 0;
      while (!charging && n < 40) begin
         run_ticks(1);
         n++;
      end
      check("low_en_ticks", n, 21);
      check("low_en_energy", energy, 21);

      // Release during charge: back to idle, no energy spent.
      fire_btn = 1'b0;
      run_ticks(1);
      check("abort_chg_charging", charging, 0);
      check("abort_chg_energy", energy, 21);

      // Normal fire from (200,300).
      fire_btn = 1'b1;
      run_ticks(4);
      check("fire_shooting", shooting, 1);
      check("fire_laser_x", laser_x, 193);
      check("fire_laser_y", laser_y, 299);
      check("fire_energy0", energy, 22);
      run_ticks(1);
      check("fire_drain", energy, 20);
      fire_btn = 1'b0;
      run_ticks(1);
      check("release_shooting", shooting, 0);
      check("release_energy", energy, 18);
      run_ticks(4);
      check("cool_no_regen", energy, 18);
      run_ticks(1);
      run_ticks(1);
      check("idle_regen", energy, 19);

      // Regen, then clamp checks while firing.
      guard = 0;
      while (m_en < 60 && guard < 100) begin
         run_ticks(1);
         guard++;
      end
      fire_btn = 1'b1;
      run_ticks(4);
      check("clamp_shooting", shooting, 1);
      player_x = 10'd3;
      run_ticks(1);
      check("clamp_x_lo", laser_x, 0);
      player_x = 10'd383;
      run_ticks(1);
      check("clamp_x_hi", laser_x, 368);
      player_y = 10'd0;
      run_ticks(1);
      check("clamp_y_lo", laser_y, 1);
      player_y = 10'd500;
      run_ticks(1);
      check("clamp_y_hi", laser_y, 447);
      player_x = 10'd200;
      player_y = 10'd300;

      // Bomb during fire: normal cooldown.
      bomb_active = 1'b1;
      run_ticks(1);
      check("bomb_shooting", shooting, 0);
      check("bomb_overheat", overheat, 0);
      bomb_active = 1'b0;
      fire_btn    = 1'b0;
      run_ticks(6);

      // Bomb inhibits leaving idle.
      bomb_active = 1'b1;
      fire_btn    = 1'b1;
      run_ticks(2);
      check("bomb_inhibit", charging, 0);
      bomb_active = 1'b0;

      // Bomb on the same tick the gauge empties: exhaustion wins.
      guard = 0;
      while (!(m_st == 2 && m_en <= DRAIN) && guard < 200) begin
         run_ticks(1);
         guard++;
      end
      bomb_active = 1'b1;
      run_ticks(1);
      check("bomb_exhaust_overheat", overheat, 1);
      check("bomb_exhaust_energy", energy, 0);
      bomb_active = 1'b0;
      fire_btn    = 1'b0;
      run_ticks(11);

      // Asynchronous reset in the middle of FIRE.
      fire_btn = 1'b1;
      guard = 0;
      while (m_st != 2 && guard < 100) begin
         run_ticks(1);
         guard++;
      end
      run_ticks(1);
      check("pre_reset_shooting", shooting, 1);
      #2 reset = 1'b1;
      #1;
      check_reset_outs("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      fire_btn = 1'b0;
      first_tick("mid_rst_first_tick");
      run_ticks(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
